alarm_trigger_module: RTL and testbench

ALARM_TRIGGER_MODULE -- requirements
Module: alarm_trigger_module

---
 rtl/alarm_trigger_module.sv | 150 +++++++++++++++
 tb/tb_alarm_trigger_module.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/alarm_trigger_module.sv
// rtl/alarm_trigger_module.sv - day-masked alarm with ring timeout, bounded snooze and stop control
module alarm_trigger_module #(
    parameter int SNOOZE_MIN = 5,
    parameter int RING_SEC   = 60,
    parameter int MAX_SNZ    = 3
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic [15:0] time_in,
    input  logic [15:0] alarm_in,
    input  logic [6:0]  day_mask,
    input  logic        AON,
    input  logic        SNZ,
    input  logic        OFF,
    input  logic        sec_tick,
    output logic        buzzer,
    output logic        ALED,
    output logic        snoozing,
    output logic [3:0]  snz_count
);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] RINGING = 2'd1;
    localparam logic [1:0] SNOOZE  = 2'd2;
    localparam logic [1:0] DONE    = 2'd3;

    localparam logic [8:0] RING_LIM  = 9'(RING_SEC);
    localparam logic [4:0] SNZ_LIM   = 5'(SNOOZE_MIN);
    localparam logic [3:0] MAX_LIM   = 4'(MAX_SNZ);

    logic [1:0] state, state_n;
    logic [7:0] sec_cnt, sec_cnt_n;
    logic [3:0] min_cnt, min_cnt_n;
    logic [3:0] cnt_n;
    logic       beep, beep_n;
    logic       match, match_q, trigger;
    logic       snz_q, off_q, snz_edge, off_edge;
    logic [5:0] min_q;
    logic       minute_chg;
    logic [7:0] day_mask_ext;
    logic [8:0] sec_inc;
    logic [4:0] min_inc;
    logic       snooze_req;
    logic       unused_bits;

    assign unused_bits = ^{time_in[1:0], alarm_in[15:13], alarm_in[1:0]};

    // Day 7 is not a valid day; the padded zero bit makes it never match.
    assign day_mask_ext = {1'b0, day_mask};
    assign match = AON
                 & (time_in[12:8] == alarm_in[12:8])
                 & (time_in[7:2]  == alarm_in[7:2])
                 & day_mask_ext[time_in[15:13]];

    assign trigger    = match & ~match_q;
    assign snz_edge   = SNZ & ~snz_q;
    assign off_edge   = OFF & ~off_q;
    assign minute_chg = (time_in[7:2] != min_q);

    assign sec_inc    = {1'b0, sec_cnt} + 9'd1;
    assign min_inc    = {1'b0, min_cnt} + 5'd1;
    assign snooze_req = snz_edge | (sec_tick & (sec_inc == RING_LIM));

    always_comb begin
        state_n   = state;
        sec_cnt_n = sec_cnt;
        min_cnt_n = min_cnt;
        cnt_n     = snz_count;
        beep_n    = beep;
        if (!AON) begin
            state_n = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (trigger) begin
                        state_n   = RINGING;
                        sec_cnt_n = 8'd0;
                        beep_n    = 1'b1;
                        cnt_n     = 4'd0;
                    end
                end
                RINGING: begin
                    // Stop has priority over both a snooze press and the ring timeout.
                    if (off_edge) begin
                        state_n = DONE;
                    end else if (snooze_req) begin
                        if (snz_count < MAX_LIM) begin
                            state_n   = SNOOZE;
                            cnt_n     = snz_count + 4'd1;
                            min_cnt_n = 4'd0;
                        end else begin
                            state_n = DONE;
                        end
                    end else if (sec_tick) begin
                        sec_cnt_n = sec_inc[7:0];
                        beep_n    = ~beep;
                    end
                end
                SNOOZE: begin
                    if (off_edge) begin
                        state_n = DONE;
                    end else if (minute_chg) begin
                        if (min_inc == SNZ_LIM) begin
                            state_n   = RINGING;
                            sec_cnt_n = 8'd0;
                            beep_n    = 1'b1;
                        end else begin
                            min_cnt_n = min_inc[3:0];
                        end
                    end
                end
                default: begin
                    if (!match) state_n = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state     <= IDLE;
            sec_cnt   <= 8'd0;
            min_cnt   <= 4'd0;
            snz_count <= 4'd0;
            beep      <= 1'b0;
            match_q   <= 1'b0;
            snz_q     <= 1'b0;
            off_q     <= 1'b0;
            min_q     <= 6'd0;
            buzzer    <= 1'b0;
            ALED      <= 1'b0;
            snoozing  <= 1'b0;
        end else begin
            state     <= state_n;
            sec_cnt   <= sec_cnt_n;
            min_cnt   <= min_cnt_n;
            snz_count <= cnt_n;
            beep      <= beep_n;
            match_q   <= match;
            snz_q     <= SNZ;
            off_q     <= OFF;
            min_q     <= time_in[7:2];
            // Outputs are decoded from next state so they land on the same edge as the state.
            buzzer    <= (state_n == RINGING) & beep_n;
            ALED      <= (state_n == RINGING) | (state_n == SNOOZE);
            snoozing  <= (state_n == SNOOZE);
        end
    end

endmodule

// File: tb/tb_alarm_trigger_module.sv
// tb/tb_alarm_trigger_module.sv - directed vector bench for alarm_trigger_module
module tb_alarm_trigger_module;

    logic        Clk = 1'b0;
    logic        Reset;
    logic [15:0] time_in;
    logic [15:0] alarm_in;
    logic [6:0]  day_mask;
    logic        AON, SNZ, OFF, sec_tick;
    logic        buzzer, ALED, snoozing;
    logic [3:0]  snz_count;

    int n_tests = 0;
    int n_fail  = 0;
    logic [2:0] cur_day = 3'd0;
    logic [5:0] cur_mn  = 6'd29;

    alarm_trigger_module #(.SNOOZE_MIN(5), .RING_SEC(60), .MAX_SNZ(3)) dut (
        .Clk(Clk), .Reset(Reset), .time_in(time_in), .alarm_in(alarm_in),
        .day_mask(day_mask), .AON(AON), .SNZ(SNZ), .OFF(OFF), .sec_tick(sec_tick),
        .buzzer(buzzer), .ALED(ALED), .snoozing(snoozing), .snz_count(snz_count)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        logic [5:0] mn;
        logic       snz, off, tick;
        logic       eb, ea, es;
        logic [3:0] ec;
    } vec_t;

    vec_t tbl [15];

    function automatic logic [15:0] tw(input logic [2:0] d, input logic [4:0] h, input logic [5:0] m);
        return {d, h, m, 2'b00};
    endfunction

    function automatic vec_t mk(input logic [5:0] mn, input logic s, input logic o, input logic t,
                                input logic eb, input logic ea, input logic es, input logic [3:0] ec);
        vec_t v;
        v.mn = mn; v.snz = s; v.off = o; v.tick = t;
        v.eb = eb; v.ea = ea; v.es = es; v.ec = ec;
        return v;
    endfunction

    task automatic chk(input string name, input logic [3:0] got, input logic [3:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
        end
    endtask

    task automatic chk_out(input string tag, input logic eb, input logic ea, input logic es, input logic [3:0] ec);
        chk({tag, ".buzzer"},   {3'b0, buzzer},   {3'b0, eb});
        chk({tag, ".ALED"},     {3'b0, ALED},     {3'b0, ea});
        chk({tag, ".snoozing"}, {3'b0, snoozing}, {3'b0, es});
        chk({tag, ".snz_count"}, snz_count, ec);
    endtask

    task automatic drive(input logic [5:0] mn, input logic s, input logic o, input logic t);
        @(negedge Clk);
        cur_mn   = mn;
        time_in  = tw(cur_day, 5'd7, mn);
        SNZ      = s;
        OFF      = o;
        sec_tick = t;
        @(posedge Clk);
        #1;
    endtask

    // Alternate 07:30/07:31 so each cycle is a minute change.
    task automatic mchg(input int n);
        for (int i = 0; i < n; i++) drive((cur_mn == 6'd30) ? 6'd31 : 6'd30, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        tbl[0]  = mk(6'd29, 0, 0, 0, 0, 0, 0, 4'd0);
        tbl[1]  = mk(6'd30, 0, 0, 0, 1, 1, 0, 4'd0);
        tbl[2]  = mk(6'd30, 0, 0, 1, 0, 1, 0, 4'd0);
        tbl[3]  = mk(6'd30, 0, 0, 1, 1, 1, 0, 4'd0);
        tbl[4]  = mk(6'd30, 0, 0, 0, 1, 1, 0, 4'd0);
        tbl[5]  = mk(6'd30, 1, 0, 0, 0, 1, 1, 4'd1);
        tbl[6]  = mk(6'd30, 0, 0, 0, 0, 1, 1, 4'd1);
        tbl[7]  = mk(6'd30, 1, 0, 0, 0, 1, 1, 4'd1);
        tbl[8]  = mk(6'd31, 0, 0, 0, 0, 1, 1, 4'd1);
        tbl[9]  = mk(6'd32, 0, 0, 0, 0, 1, 1, 4'd1);
        tbl[10] = mk(6'd33, 0, 0, 0, 0, 1, 1, 4'd1);
        tbl[11] = mk(6'd34, 0, 0, 0, 0, 1, 1, 4'd1);
        tbl[12] = mk(6'd35, 0, 0, 0, 1, 1, 0, 4'd1);
        tbl[13] = mk(6'd35, 0, 1, 0, 0, 0, 0, 4'd1);
        tbl[14] = mk(6'd35, 0, 0, 0, 0, 0, 0, 4'd1);

        Reset = 1'b1; AON = 1'b1; SNZ = 1'b0; OFF = 1'b0; sec_tick = 1'b0;
        day_mask = 7'h7F;
        alarm_in = tw(3'd0, 5'd7, 6'd30);
        time_in  = tw(3'd0, 5'd7, 6'd29);
        repeat (2) @(posedge Clk);
        #1;
        chk_out("reset", 0, 0, 0, 4'd0);
        @(negedge Clk);
        Reset = 1'b0;

        for (int i = 0; i < 15; i++) begin
            drive(tbl[i].mn, tbl[i].snz, tbl[i].off, tbl[i].tick);
            chk_out($sformatf("vec%0d", i), tbl[i].eb, tbl[i].ea, tbl[i].es, tbl[i].ec);
        end

        // Ring timeout, then exhaust snoozes
        drive(6'd29, 0, 0, 0);
        drive(6'd30, 0, 0, 0);
        chk_out("to.start", 1, 1, 0, 4'd0);
        for (int i = 0; i < 59; i++) drive(6'd30, 0, 0, 1);
        chk_out("to.tick59", 0, 1, 0, 4'd0);
        drive(6'd30, 0, 0, 1);
        chk_out("to.tick60", 0, 1, 1, 4'd1);
        mchg(5);
        chk_out("to.ring2", 1, 1, 0, 4'd1);
        drive(cur_mn, 1, 0, 0);
        chk_out("to.snz2", 0, 1, 1, 4'd2);
        mchg(5);
        drive(cur_mn, 1, 0, 0);
        chk_out("to.snz3", 0, 1, 1, 4'd3);
        mchg(5);
        chk_out("to.ring4", 1, 1, 0, 4'd3);
        drive(6'd30, 0, 0, 0);
        chk_out("to.back30", 1, 1, 0, 4'd3);
        drive(6'd30, 1, 0, 0);
        chk_out("to.snz4done", 0, 0, 0, 4'd3);
        for (int i = 0; i < 3; i++) begin
            drive(6'd30, 0, 0, 0);
            chk_out($sformatf("to.hold%0d", i), 0, 0, 0, 4'd3);
        end
        drive(6'd31, 0, 0, 0);
        chk_out("to.leave", 0, 0, 0, 4'd3);
        drive(6'd30, 0, 0, 0);
        chk_out("to.retrig", 1, 1, 0, 4'd0);

        // SNZ and OFF together
        drive(6'd30, 1, 0, 0);
        chk_out("both.snz", 0, 1, 1, 4'd1);
        mchg(5);
        chk_out("both.ring", 1, 1, 0, 4'd1);
        drive(cur_mn, 1, 1, 0);
        chk_out("both.done", 0, 0, 0, 4'd1);
        drive(6'd32, 0, 0, 0);
        chk_out("both.idle", 0, 0, 0, 4'd1);

        // Day mask
        day_mask = 7'h01;
        cur_day = 3'd1;
        drive(6'd29, 0, 0, 0);
        drive(6'd30, 0, 0, 0);
        chk_out("day1", 0, 0, 0, 4'd1);
        cur_day = 3'd0;
        drive(6'd30, 0, 0, 0);
        chk_out("day0", 1, 1, 0, 4'd0);
        drive(6'd30, 0, 1, 0);
        chk_out("day0.off", 0, 0, 0, 4'd0);
        day_mask = 7'h7F;
        cur_day = 3'd7;
        drive(6'd31, 0, 0, 0);
        drive(6'd30, 0, 0, 0);
        chk_out("day7", 0, 0, 0, 4'd0);

        // Async reset mid-ring, power-on trigger, AON drop in snooze
        cur_day = 3'd0;
        drive(6'd29, 0, 0, 0);
        drive(6'd30, 0, 0, 0);
        drive(6'd30, 1, 0, 0);
        mchg(5);
        chk_out("rst.ring", 1, 1, 0, 4'd1);
        #2;
        Reset = 1'b1;
        #1;
        chk_out("rst.async", 0, 0, 0, 4'd0);
        @(negedge Clk);
        time_in = tw(3'd0, 5'd7, 6'd30);
        cur_mn  = 6'd30;
        Reset   = 1'b0;
        @(posedge Clk);
        #1;
        chk_out("rst.poweron", 1, 1, 0, 4'd0);
        drive(6'd30, 1, 0, 0);
        chk_out("aon.snz", 0, 1, 1, 4'd1);
        AON = 1'b0;
        drive(6'd30, 0, 0, 0);
        chk_out("aon.drop", 0, 0, 0, 4'd1);
        AON = 1'b1;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
